multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM control unit for the multicycle MIPS datapath. Replaces single-cycle opcode decode.
//  Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction; stalls on a memory-ready handshake.
//  Adds SW, J, JAL, JR and a memory-wait timeout. Sits between the IR opcode/funct fields and the datapath.
// PARAMETERS
//  ALUOP_W    3   width of ALUOp; must be >= 3, codes zero-extended into upper bits
//  MAX_WAIT   15  max cycles spent waiting on mem_ready before bus_error; counter width $clog2(MAX_WAIT+1)
//  STATE_W    4   width of state register / state_o
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  OP           in   6        IR[31:26] opcode (valid from DECODE onward)
//  Funct        in   6        IR[5:0] function field (used for JR only)
//  mem_ready    in   1        memory completed the access this cycle
//  PCWrite      out  1        unconditional PC load
//  BranchEQ     out  1        PC load if ALU zero
//  BranchNE     out  1        PC load if ALU not zero
//  IorD         out  1        memory address: 0 = PC, 1 = ALUOut
//  MemRead      out  1        memory read strobe
//  MemWrite     out  1        memory write strobe
//  IRWrite      out  1        load instruction register
//  RegDst       out  2        0 = rt, 1 = rd, 2 = $31
//  MemtoReg     out  2        0 = ALUOut, 1 = MDR, 2 = PC (link)
//  RegWrite     out  1        register file write
//  ALUSrcA      out  1        0 = PC, 1 = rs
//  ALUSrcB      out  2        0 = rt, 1 = const 4, 2 = sign/zero-ext imm, 3 = imm<<2
//  PCSource     out  2        0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs (JR)
//  ALUOp        out  ALUOP_W  ADD=010 SUB=100 R=111 ADDI=110 ANDI=011 ORI=101 LUI=001
//  bus_error    out  1        one-cycle pulse on mem-wait timeout
//  state_o      out  STATE_W  current state (debug)
// BEHAVIOUR
//  - Outputs are pure decodes of the state register (Moore); no OP-to-output combinational path
//    except state-transition logic.
//  - reset: state <= RESET, wait_cnt <= 0. In RESET every output is 0; RESET -> FETCH unconditionally.
//  - FETCH: MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCWrite, PCSource=0.
//    IRWrite/PCWrite asserted only in the cycle mem_ready=1; else hold state.
//  - DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target). Dispatch on OP:
//    0x00 -> (Funct 0x08 ? JR : EXEC_R); 0x08/0x0C/0x0D/0x0F -> EXEC_I; 0x23/0x2B -> MEM_ADDR;
//    0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x03 -> JAL; other -> FETCH (illegal op = NOP).
//  - EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=R -> WB_R (RegDst=1, MemtoReg=0, RegWrite) -> FETCH.
//  - EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp per opcode -> WB_I (RegDst=0, MemtoReg=0, RegWrite) -> FETCH.
//  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD -> MEM_RD (LW) or MEM_WR (SW).
//  - MEM_RD: MemRead, IorD=1; on mem_ready -> WB_MEM (RegDst=0, MemtoReg=1, RegWrite) -> FETCH.
//  - MEM_WR: MemWrite, IorD=1; on mem_ready -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1; BranchEQ (0x04) or BranchNE (0x05).
//    Opcode latched in DECODE, since IR is stable. -> FETCH.
//  - JUMP: PCWrite, PCSource=2 -> FETCH.
//  - JAL: RegDst=2, MemtoReg=2, RegWrite, PCWrite, PCSource=2 -> FETCH.
//    Link value = PC already incremented in FETCH.
//  - JR: PCWrite, PCSource=3 -> FETCH.
//  - wait_cnt: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each waiting cycle with mem_ready=0.
//    Saturates at MAX_WAIT. If wait_cnt==MAX_WAIT and mem_ready=0: bus_error pulses 1 cycle,
//    all strobes drop, state -> FETCH. The faulting instruction is abandoned and PC is unchanged.
//  - mem_ready outside the three memory states is ignored.
//  - reset mid-instruction: all strobes drop asynchronously in the same cycle; no partial write completes.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode/funct localparams, ALUOp codes, state encodings,
//    and RegDst/MemtoReg/ALUSrcB/PCSource mux-select encodings shared with the datapath.
//  - One sub-module, mem_wait_timer (counter + timeout compare).
//    FSM next-state and output decode stay in this module.
// TESTING
//  1. reset high mid-MEM_WR -> MemWrite=0 immediately; after release: RESET (all 0), then FETCH.
//  2. OP=0x00, Funct=0x20, mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_R; RegWrite=1 only in WB_R; 4 cycles.
//  3. OP=0x23, mem_ready low 3 cycles in MEM_RD -> MemRead held 4 cycles; WB_MEM has MemtoReg=1.
//  4. OP=0x05 -> BRANCH asserts BranchNE=1, BranchEQ=0, ALUOp=100, PCSource=1; 3 cycles total.
//  5. OP=0x03 -> JAL cycle: RegDst=2, MemtoReg=2, RegWrite=1, PCWrite=1, PCSource=2.
//  6. mem_ready held 0 in FETCH, MAX_WAIT=15 -> bus_error=1 exactly once, at cycle 16; IRWrite never 1;
//     next state FETCH. OP=0x3F -> DECODE then FETCH, no strobes.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ALUOp codes, FSM states and datapath mux selects for the multicycle control unit
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b100, ALU_R = 3'b111, ALU_ADDI = 3'b110,
                         ALU_ANDI = 3'b011, ALU_ORI = 3'b101, ALU_LUI = 3'b001;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
  localparam logic [1:0] SRCB_RT = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM4 = 2'd3;
  localparam logic [1:0] PCS_ALU = 2'd0, PCS_ALUOUT = 2'd1, PCS_JUMP = 2'd2, PCS_RS = 2'd3;
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    return op == OP_ANDI ? ALU_ANDI : op == OP_ORI ? ALU_ORI : op == OP_LUI ? ALU_LUI : ALU_ADDI;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory-wait cycles and flags a timeout once MAX_WAIT cycles have elapsed
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic timeout
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  assign timeout = waiting && cnt == CW'(MAX_WAIT);
  // any non-waiting cycle clears, so every entry into a memory state starts from zero
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (waiting && !timeout) ? cnt + CW'(1) : '0;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath with memory handshake and timeout
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter int MAX_WAIT = 15,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               BranchEQ,
  output logic               BranchNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               bus_error,
  output logic [STATE_W-1:0] state_o
);
  state_t state, state_d;
  logic [5:0] op_q;
  logic [2:0] alu;
  logic waiting, timeout;
  assign waiting = state inside {S_FETCH, S_MEM_RD, S_MEM_WR} && !mem_ready;
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk), .reset(reset), .waiting(waiting), .timeout(timeout)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_RESET;
      op_q  <= '0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) op_q <= OP;
    end
  always_comb begin
    state_d = state;
    case (state)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = OP == OP_RTYPE ? (Funct == FN_JR ? S_JR : S_EXEC_R) :
                            OP inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LUI} ? S_EXEC_I :
                            OP inside {OP_LW, OP_SW} ? S_MEM_ADDR :
                            OP inside {OP_BEQ, OP_BNE} ? S_BRANCH :
                            OP == OP_J ? S_JUMP : OP == OP_JAL ? S_JAL : S_FETCH;
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = op_q == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : timeout ? S_FETCH : S_MEM_RD;
      S_MEM_WR:   state_d = (mem_ready || timeout) ? S_FETCH : S_MEM_WR;
      default:    state_d = S_FETCH;
    endcase
  end
  always_comb begin
    {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA} = '0;
    RegDst   = DST_RT;
    MemtoReg = M2R_ALU;
    ALUSrcB  = SRCB_RT;
    PCSource = PCS_ALU;
    alu      = 3'b000;
    case (state)
      S_FETCH: begin
        MemRead = !timeout;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        ALUSrcB = SRCB_4;
        alu     = ALU_ADD;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM4;
        alu     = ALU_ADD;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        alu     = ALU_R;
      end
      S_WB_R: begin
        RegDst   = DST_RD;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu     = imm_aluop(op_q);
      end
      S_WB_I: RegWrite = 1'b1;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu     = ALU_ADD;
      end
      S_MEM_RD: begin
        MemRead = !timeout;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = !timeout;
        IorD     = 1'b1;
      end
      S_WB_MEM: begin
        MemtoReg = M2R_MDR;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu      = ALU_SUB;
        PCSource = PCS_ALUOUT;
        BranchEQ = op_q == OP_BEQ;
        BranchNE = op_q == OP_BNE;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JAL: begin
        RegDst   = DST_RA;
        MemtoReg = M2R_PC;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCS_RS;
      end
      default: ;
    endcase
  end
  assign ALUOp     = ALUOP_W'(alu);
  assign bus_error = timeout;
  assign state_o   = STATE_W'(state);
endmodule
